// File: rtl/rv32i_alu_if.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_alu_if
// Brief    : Operand/control/result bundle between the RV32I datapath and ALU.
// Revision : 1.0 - initial release
// ============================================================================
interface rv32i_alu_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] result;
  logic             equal;
  logic             less_than;
  logic             less_than_unsigned;
  logic [WIDTH-1:0] result_q;

  modport master (
    output alu_control, A, B,
    input  result, equal, less_than, less_than_unsigned, result_q
  );

  modport slave (
    input  alu_control, A, B,
    output result, equal, less_than, less_than_unsigned, result_q
  );
endinterface
`default_nettype wire

// File: rtl/rv32i_alu.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_alu
// Brief    : RV32I integer ALU with always-valid compare flags and a
//            registered copy of the result.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_alu #(
  parameter int WIDTH = 32
) (
  input  wire logic      clk,
  input  wire logic      reset,
  rv32i_alu_if.slave     alu
);

  localparam int c_SHAMT_W = $clog2(WIDTH);

  // Control code is {funct7[5], funct3}
  localparam logic [3:0] c_OP_ADD   = 4'b0000;
  localparam logic [3:0] c_OP_SUB   = 4'b1000;
  localparam logic [3:0] c_OP_SLL   = 4'b0001;
  localparam logic [3:0] c_OP_SLT   = 4'b0010;
  localparam logic [3:0] c_OP_SLTU  = 4'b0011;
  localparam logic [3:0] c_OP_XOR   = 4'b0100;
  localparam logic [3:0] c_OP_SRL   = 4'b0101;
  localparam logic [3:0] c_OP_SRA   = 4'b1101;
  localparam logic [3:0] c_OP_OR    = 4'b0110;
  localparam logic [3:0] c_OP_AND   = 4'b0111;
  localparam logic [3:0] c_OP_PASSB = 4'b1001;

  logic [c_SHAMT_W-1:0] w_shamt;
  logic                 w_lt;
  logic                 w_ltu;
  logic [WIDTH-1:0]     w_result;
  logic [WIDTH-1:0]     r_result_q;

  assign w_shamt = alu.B[c_SHAMT_W-1:0];
  assign w_lt    = $signed(alu.A) < $signed(alu.B);
  assign w_ltu   = alu.A < alu.B;

  always_comb begin
    w_result = '0;
    unique case (alu.alu_control)
      c_OP_ADD:   w_result = alu.A + alu.B;
      c_OP_SUB:   w_result = alu.A - alu.B;
      c_OP_SLL:   w_result = alu.A << w_shamt;
      c_OP_SLT:   w_result = {{(WIDTH-1){1'b0}}, w_lt};
      c_OP_SLTU:  w_result = {{(WIDTH-1){1'b0}}, w_ltu};
      c_OP_XOR:   w_result = alu.A ^ alu.B;
      c_OP_SRL:   w_result = alu.A >> w_shamt;
      c_OP_SRA:   w_result = $unsigned($signed(alu.A) >>> w_shamt);
      c_OP_OR:    w_result = alu.A | alu.B;
      c_OP_AND:   w_result = alu.A & alu.B;
      c_OP_PASSB: w_result = alu.B;
      default:    w_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_result_q <= '0;
    end else begin
      r_result_q <= w_result;
    end
  end

  assign alu.result             = w_result;
  assign alu.equal              = (alu.A == alu.B);
  assign alu.less_than          = w_lt;
  assign alu.less_than_unsigned = w_ltu;
  assign alu.result_q           = r_result_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_alu
// Brief    : Scoreboard bench for rv32i_alu combinational and registered paths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_alu;

  typedef struct packed {
    logic [31:0] res;
    logic        eq;
    logic        lt;
    logic        ltu;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  exp_t        exp_q[$];
  logic [31:0] rq_q[$];

  rv32i_alu_if #(.WIDTH(32)) bus ();

  rv32i_alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .alu   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference model built from first principles rather than HDL operators
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] r;
    int          sh;
    sh    = int'(b[4:0]);
    e.eq  = (a == b);
    e.ltu = (a < b);
    e.lt  = (a[31] != b[31]) ? a[31] : (a < b);
    r     = 32'h0;
    case (c)
      4'b0000: r = a + b;
      4'b1000: r = a + ~b + 32'd1;
      4'b0001: begin r = a; for (int i = 0; i < sh; i++) r = {r[30:0], 1'b0}; end
      4'b0010: r = {31'b0, e.lt};
      4'b0011: r = {31'b0, e.ltu};
      4'b0100: r = a ^ b;
      4'b0101: begin r = a; for (int i = 0; i < sh; i++) r = {1'b0, r[31:1]}; end
      4'b1101: begin r = a; for (int i = 0; i < sh; i++) r = {r[31], r[31:1]}; end
      4'b0110: r = a | b;
      4'b0111: r = a & b;
      4'b1001: r = b;
      default: r = 32'h0;
    endcase
    e.res = r;
    return e;
  endfunction

  // Drive at negedge, check combinational outputs, then result_q after the edge
  task automatic apply(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] rq;
    @(negedge clk);
    bus.alu_control = c;
    bus.A           = a;
    bus.B           = b;
    exp_q.push_back(model(c, a, b));
    rq_q.push_back(reset ? model(c, a, b).res : 32'h0);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".result"}, bus.result, e.res);
      check({tag, ".equal"}, {31'b0, bus.equal}, {31'b0, e.eq});
      check({tag, ".lt"}, {31'b0, bus.less_than}, {31'b0, e.lt});
      check({tag, ".ltu"}, {31'b0, bus.less_than_unsigned}, {31'b0, e.ltu});
    end
    @(posedge clk);
    #1;
    if (rq_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s registered scoreboard empty", tag);
    end else begin
      rq = rq_q.pop_front();
      check({tag, ".result_q"}, bus.result_q, rq);
    end
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    reset           = 1'b0;
    bus.alu_control = 4'b0000;
    bus.A           = 32'd2;
    bus.B           = 32'd3;

    // Registered path and reset behaviour
    @(posedge clk); #1;
    check("reset.result_q", bus.result_q, 32'h0);
    check("reset.result_comb", bus.result, 32'd5);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("add.result_q", bus.result_q, 32'd5);
    @(negedge clk); reset = 1'b0;
    #1;
    check("midreset.result_q_hold", bus.result_q, 32'd5);
    check("midreset.result_comb", bus.result, 32'd5);
    @(posedge clk); #1;
    check("midreset.result_q", bus.result_q, 32'h0);
    @(negedge clk); reset = 1'b1;

    // Directed vectors
    apply("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001);
    apply("sub_wrap", 4'b1000, 32'h0000_0000, 32'h0000_0001);
    apply("srl",      4'b0101, 32'h8000_0000, 32'h0000_0024);
    apply("sra",      4'b1101, 32'h8000_0000, 32'h0000_0024);
    apply("sll",      4'b0001, 32'h0000_0001, 32'h0000_001F);
    apply("sll0",     4'b0001, 32'hDEAD_BEEF, 32'hFFFF_FFE0);
    apply("slt",      4'b0010, 32'hFFFF_FFFF, 32'h0000_0001);
    apply("sltu",     4'b0011, 32'hFFFF_FFFF, 32'h0000_0001);
    apply("and",      4'b0111, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    apply("or",       4'b0110, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    apply("xor",      4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    apply("passb",    4'b1001, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    apply("undef",    4'b1111, 32'hF0F0_F0F0, 32'h0FF0_0FF0);

    // Spot-check the literal test-plan values on top of the model
    @(negedge clk);
    bus.alu_control = 4'b1101; bus.A = 32'h8000_0000; bus.B = 32'h0000_0024;
    #1 check("plan.sra", bus.result, 32'hF800_0000);
    bus.alu_control = 4'b1000; bus.A = 32'h0; bus.B = 32'h1;
    #1 check("plan.sub", bus.result, 32'hFFFF_FFFF);
    bus.alu_control = 4'b0010; bus.A = 32'hFFFF_FFFF; bus.B = 32'h1;
    #1 check("plan.slt", bus.result, 32'h1);
    check("plan.ltu_flag", {31'b0, bus.less_than_unsigned}, 32'h0);

    // Flags under every control code, including undefined ones
    for (int c = 0; c < 16; c++) begin
      apply($sformatf("flags_c%0d", c), 4'(c), 32'h1234_5678, 32'h1234_5678);
    end

    // Random sweep, with a share of equal operands and sign-boundary values
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom();
      b = $urandom();
      if (i % 7 == 0) b = a;
      if (i % 11 == 0) a = 32'h8000_0000;
      apply($sformatf("rand%0d", i), 4'($urandom_range(0, 15)), a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
